// File: rtl/vpu_controller.sv
// vpu_controller
//   Sequencing controller for the VPU datapath. Pops one decoded instruction
//   from the decoder request FIFO, latches its operand descriptor and, for
//   every vector beat, issues SRAM operand reads, waits out the SRAM read
//   latency, starts the execution unit, waits for completion and issues the
//   SRAM write-back.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid_i     : decoder FIFO non-empty (head fields valid while high)
//   req_rvalid_i    : per-port source-operand used flags
//   req_raddr_i     : per-port source base addresses, port i at [i*AW +: AW]
//   req_vlen_i      : beat count minus one
//   req_waddr_i     : destination base address
//   rden_o          : FIFO pop strobe (combinational)
//   sram_ren_o      : per-port SRAM read enable
//   sram_raddr_o    : per-port SRAM read address (0 when port disabled)
//   exec_start_o    : one-cycle execution start pulse
//   exec_done_i     : execution unit result valid
//   sram_wen_o      : write-back enable
//   sram_waddr_o    : write-back address
//   busy_o          : controller not idle
//   done_o          : pulse with the final write of an instruction
module vpu_controller #(
  parameter int SRAM_R_PORT_CNT    = 3,
  parameter int OPERAND_ADDR_WIDTH = 10,
  parameter int VEC_LEN_LG2        = 4,
  parameter int SRAM_RD_LATENCY    = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req_valid_i,
  input  logic [SRAM_R_PORT_CNT-1:0]                    req_rvalid_i,
  input  logic [SRAM_R_PORT_CNT*OPERAND_ADDR_WIDTH-1:0] req_raddr_i,
  input  logic [VEC_LEN_LG2-1:0]                        req_vlen_i,
  input  logic [OPERAND_ADDR_WIDTH-1:0]                 req_waddr_i,
  output logic                                          rden_o,
  output logic [SRAM_R_PORT_CNT-1:0]                    sram_ren_o,
  output logic [SRAM_R_PORT_CNT*OPERAND_ADDR_WIDTH-1:0] sram_raddr_o,
  output logic                                          exec_start_o,
  input  logic                                          exec_done_i,
  output logic                                          sram_wen_o,
  output logic [OPERAND_ADDR_WIDTH-1:0]                 sram_waddr_o,
  output logic                                          busy_o,
  output logic                                          done_o
);

  localparam int unsigned RP  = SRAM_R_PORT_CNT;
  localparam int unsigned AW  = OPERAND_ADDR_WIDTH;
  localparam int unsigned VL  = VEC_LEN_LG2;
  // Holds SRAM_RD_LATENCY-2, at most 6 for the legal latency range.
  localparam int unsigned WCW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RWAIT,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [RP-1:0]       rvalid_q, rvalid_d;
  logic [RP*AW-1:0]    raddr_q, raddr_d;
  logic [VL-1:0]       vlen_q, vlen_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [VL-1:0]       beat_q, beat_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;

  logic [RP-1:0]       ren_d;
  logic [RP*AW-1:0]    rd_addr_d;
  logic                start_d;
  logic                wen_d;
  logic [AW-1:0]       wr_addr_d;
  logic                busy_d;
  logic                done_d;

  // Pop strobe; gated by rst_n so every output is quiet while in reset.
  assign rden_o = (state_q == S_IDLE) && req_valid_i && rst_n;

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    rvalid_d = rvalid_q;
    raddr_d  = raddr_q;
    vlen_d   = vlen_q;
    waddr_d  = waddr_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          rvalid_d = req_rvalid_i;
          raddr_d  = req_raddr_i;
          vlen_d   = req_vlen_i;
          waddr_d  = req_waddr_i;
          beat_d   = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (SRAM_RD_LATENCY <= 1) begin
          state_d = S_EXEC;
        end else begin
          wcnt_d  = WCW'(SRAM_RD_LATENCY - 2);
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_EXEC;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (beat_q == vlen_q) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state/registers so that, once
  // registered, they line up with the cycle spent in the matching state.
  always_comb begin
    ren_d     = '0;
    rd_addr_d = '0;
    if (state_d == S_READ) begin
      ren_d = rvalid_d;
    end
    for (int unsigned i = 0; i < RP; i++) begin
      if (ren_d[i]) begin
        rd_addr_d[i*AW +: AW] = raddr_d[i*AW +: AW] + AW'(beat_d);
      end
    end
    start_d   = (state_d == S_EXEC) && (state_q != S_EXEC);
    wen_d     = (state_d == S_WRITE);
    wr_addr_d = wen_d ? (waddr_d + AW'(beat_d)) : '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_WRITE) && (beat_d == vlen_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rvalid_q     <= '0;
      raddr_q      <= '0;
      vlen_q       <= '0;
      waddr_q      <= '0;
      beat_q       <= '0;
      wcnt_q       <= '0;
      sram_ren_o   <= '0;
      sram_raddr_o <= '0;
      exec_start_o <= 1'b0;
      sram_wen_o   <= 1'b0;
      sram_waddr_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= rvalid_d;
      raddr_q      <= raddr_d;
      vlen_q       <= vlen_d;
      waddr_q      <= waddr_d;
      beat_q       <= beat_d;
      wcnt_q       <= wcnt_d;
      sram_ren_o   <= ren_d;
      sram_raddr_o <= rd_addr_d;
      exec_start_o <= start_d;
      sram_wen_o   <= wen_d;
      sram_waddr_o <= wr_addr_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
    end
  end

endmodule

// File: tb/tb_vpu_controller.sv
// Testbench for vpu_controller: two instances (read latency 1 and 3) are fed
// from per-instance stimulus queues; the expected per-cycle output trace is
// derived from the beat timing rules and checked by a separate monitor.
module tb_vpu_controller;

  localparam int AW = 10;
  localparam int RP = 3;

  typedef struct packed {
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  rvalid;
    logic [29:0] raddr;
    logic [3:0]  vlen;
    logic [9:0]  waddr;
    logic        exec_done;
  } stim_t;

  typedef struct packed {
    logic        rden;
    logic [2:0]  ren;
    logic [29:0] raddr;
    logic        start;
    logic        wen;
    logic [9:0]  waddr;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n_v;
  logic [1:0]       req_valid_v;
  logic [1:0][2:0]  req_rvalid_v;
  logic [1:0][29:0] req_raddr_v;
  logic [1:0][3:0]  req_vlen_v;
  logic [1:0][9:0]  req_waddr_v;
  logic [1:0]       exec_done_v;
  logic [1:0]       rden_v;
  logic [1:0][2:0]  ren_v;
  logic [1:0][29:0] sraddr_v;
  logic [1:0]       start_v;
  logic [1:0]       wen_v;
  logic [1:0][9:0]  swaddr_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;

  vpu_controller #(.SRAM_R_PORT_CNT(3), .OPERAND_ADDR_WIDTH(10),
                   .VEC_LEN_LG2(4), .SRAM_RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n_v[0]), .req_valid_i(req_valid_v[0]),
    .req_rvalid_i(req_rvalid_v[0]), .req_raddr_i(req_raddr_v[0]),
    .req_vlen_i(req_vlen_v[0]), .req_waddr_i(req_waddr_v[0]),
    .rden_o(rden_v[0]), .sram_ren_o(ren_v[0]), .sram_raddr_o(sraddr_v[0]),
    .exec_start_o(start_v[0]), .exec_done_i(exec_done_v[0]),
    .sram_wen_o(wen_v[0]), .sram_waddr_o(swaddr_v[0]),
    .busy_o(busy_v[0]), .done_o(done_v[0])
  );

  vpu_controller #(.SRAM_R_PORT_CNT(3), .OPERAND_ADDR_WIDTH(10),
                   .VEC_LEN_LG2(4), .SRAM_RD_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n_v[1]), .req_valid_i(req_valid_v[1]),
    .req_rvalid_i(req_rvalid_v[1]), .req_raddr_i(req_raddr_v[1]),
    .req_vlen_i(req_vlen_v[1]), .req_waddr_i(req_waddr_v[1]),
    .rden_o(rden_v[1]), .sram_ren_o(ren_v[1]), .sram_raddr_o(sraddr_v[1]),
    .exec_start_o(start_v[1]), .exec_done_i(exec_done_v[1]),
    .sram_wen_o(wen_v[1]), .sram_waddr_o(swaddr_v[1]),
    .busy_o(busy_v[1]), .done_o(done_v[1])
  );

  stim_t sq0[$], sq1[$];
  exp_t  eq0[$], eq1[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic push(input int k, input stim_t s, input exp_t e);
    if (k == 0) begin sq0.push_back(s); eq0.push_back(e); end
    else        begin sq1.push_back(s); eq1.push_back(e); end
  endtask

  // Random inputs for cycles where the controller must ignore them.
  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst_n     = 1'b1;
    s.req_valid = 1'($urandom);
    s.rvalid    = 3'($urandom);
    s.raddr     = 30'($urandom);
    s.vlen      = 4'($urandom);
    s.waddr     = 10'($urandom);
    s.exec_done = 1'($urandom);
    return s;
  endfunction

  task automatic idle(input int k, input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = rnd_stim();
      s.req_valid = 1'b0;
      push(k, s, '0);
    end
  endtask

  task automatic reset_cycles(input int k, input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = rnd_stim();
      s.rst_n = 1'b0;
      s.req_valid = 1'b0;
      push(k, s, '0);
    end
  endtask

  // One instruction: pop cycle, then per beat READ, lat-1 waits, exec
  // cycles (dly extra cycles, -1 = random 0..3) and WRITE. abort >= 0 asserts
  // reset on the first exec cycle of that beat.
  task automatic plan(input int k, input int lat, input logic [2:0] rv,
                      input logic [29:0] ra, input int vl,
                      input logic [9:0] wa, input int dly, input int abort);
    stim_t s;
    exp_t  e;
    int    n;
    s = rnd_stim();
    s.req_valid = 1'b1;
    s.rvalid = rv; s.raddr = ra; s.vlen = 4'(vl); s.waddr = wa;
    e = '0; e.rden = 1'b1;
    push(k, s, e);
    for (int b = 0; b <= vl; b++) begin
      e = '0; e.busy = 1'b1; e.ren = rv;
      for (int i = 0; i < RP; i++)
        if (rv[i]) e.raddr[i*AW +: AW] = 10'((int'(ra[i*AW +: AW]) + b) % 1024);
      push(k, rnd_stim(), e);
      for (int w = 1; w < lat; w++) begin
        e = '0; e.busy = 1'b1;
        push(k, rnd_stim(), e);
      end
      if (b == abort) begin
        reset_cycles(k, 2);
        idle(k, 1);
        return;
      end
      n = (dly >= 0) ? dly : int'($urandom_range(0, 3));
      for (int j = 0; j <= n; j++) begin
        s = rnd_stim();
        s.exec_done = (j == n);
        e = '0; e.busy = 1'b1; e.start = (j == 0);
        push(k, s, e);
      end
      e = '0; e.busy = 1'b1; e.wen = 1'b1;
      e.waddr = 10'((int'(wa) + b) % 1024);
      e.done = (b == vl);
      push(k, rnd_stim(), e);
    end
  endtask

  task automatic build(input int k);
    int lat;
    lat = (k == 0) ? 1 : 3;
    reset_cycles(k, 3);
    idle(k, 2);
    plan(k, lat, 3'b011, {10'h000, 10'h020, 10'h010}, 0, 10'h040, 0, -1);
    idle(k, 1);
    plan(k, lat, 3'b101, {10'h3FE, 10'h003, 10'h3FE}, 3, 10'h3FF, 0, -1);
    idle(k, 2);
    plan(k, lat, 3'b111, 30'($urandom), 0, 10'($urandom), 5, -1);
    idle(k, 1);
    plan(k, lat, 3'($urandom), 30'($urandom), 1, 10'($urandom), -1, -1);
    plan(k, lat, 3'b000, 30'($urandom), 2, 10'($urandom), -1, -1);
    idle(k, 1);
    plan(k, lat, 3'($urandom), 30'($urandom), 15, 10'($urandom), -1, -1);
    idle(k, 1);
    plan(k, lat, 3'b111, 30'($urandom), 3, 10'($urandom), 1, 2);
    plan(k, lat, 3'($urandom), 30'($urandom), 1, 10'($urandom), -1, -1);
    for (int r = 0; r < 25; r++) begin
      idle(k, int'($urandom_range(0, 2)));
      plan(k, lat, 3'($urandom), 30'($urandom), int'($urandom_range(0, 5)),
           10'($urandom), -1, -1);
    end
    idle(k, 3);
  endtask

  task automatic apply(input int k, input stim_t s);
    rst_n_v[k]      = s.rst_n;
    req_valid_v[k]  = s.req_valid;
    req_rvalid_v[k] = s.rvalid;
    req_raddr_v[k]  = s.raddr;
    req_vlen_v[k]   = s.vlen;
    req_waddr_v[k]  = s.waddr;
    exec_done_v[k]  = s.exec_done;
  endtask

  task automatic chk(input int k, input int cyc, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL u%0d %s cyc=%0d act=%0h exp=%0h", k, nm, cyc, act, req);
    end
  endtask

  task automatic drive_loop();
    int    n;
    stim_t s;
    n = (sq0.size() > sq1.size()) ? sq0.size() : sq1.size();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        s = '0; s.rst_n = 1'b1;
        if (k == 0 && sq0.size() > 0) s = sq0.pop_front();
        if (k == 1 && sq1.size() > 0) s = sq1.pop_front();
        apply(k, s);
      end
    end
  endtask

  task automatic monitor_loop();
    int   n;
    exp_t e, a;
    n = (eq0.size() > eq1.size()) ? eq0.size() : eq1.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && eq0.size() > 0) || (k == 1 && eq1.size() > 0)) begin
          e = (k == 0) ? eq0.pop_front() : eq1.pop_front();
          a.rden = rden_v[k];  a.ren = ren_v[k];    a.raddr = sraddr_v[k];
          a.start = start_v[k]; a.wen = wen_v[k];   a.waddr = swaddr_v[k];
          a.busy = busy_v[k];  a.done = done_v[k];
          chk(k, c, "rden",       32'(a.rden),  32'(e.rden));
          chk(k, c, "sram_ren",   32'(a.ren),   32'(e.ren));
          chk(k, c, "sram_raddr", 32'(a.raddr), 32'(e.raddr));
          chk(k, c, "exec_start", 32'(a.start), 32'(e.start));
          chk(k, c, "sram_wen",   32'(a.wen),   32'(e.wen));
          chk(k, c, "sram_waddr", 32'(a.waddr), 32'(e.waddr));
          chk(k, c, "busy",       32'(a.busy),  32'(e.busy));
          chk(k, c, "done",       32'(a.done),  32'(e.done));
        end
      end
    end
  endtask

  initial begin
    apply(0, '0);
    apply(1, '0);
    build(0);
    build(1);
    fork
      drive_loop();
      monitor_loop();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
